// File: rtl/core_inst_seq.sv
// Autonomous instruction sequencer for one convolution layer: emits the 34-bit
// core word (weight fetch/load, activation fetch, execute, psum drain) per kij.
module core_inst_seq #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int n_kij   = 9,
  parameter int n_act   = 36,
  parameter int n_out   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [addr_bw-1:0] x_w_base,
  input  logic [addr_bw-1:0] x_act_base,
  input  logic [addr_bw-1:0] p_base,
  input  logic               l0_o_full,
  input  logic               ofifo_valid,
  output logic [33:0]        inst,
  output logic               busy,
  output logic               done,
  output logic [3:0]         kij
);

  typedef enum logic [3:0] {
    IDLE, W_FETCH, W_LOAD, W_GAP, A_FETCH, EXEC, DRAIN, NEXT, FIN
  } state_t;

  localparam int          CW        = 16;
  localparam logic [33:0] IDLE_WORD = 34'h1800C0000;
  localparam logic [3:0]  KIJ_LAST  = 4'(n_kij - 1);

  state_t              state_r, state_s;
  logic [CW-1:0]       cnt_r, cnt_s;
  logic [3:0]          kij_r, kij_s;
  logic [33:0]         inst_r, word_s;
  logic                busy_r, done_r, take_s, l0_wr_s;
  logic [addr_bw-1:0]  w_addr_s, a_addr_s, p_addr_s;
  logic                acc_f, cen_p, wen_p, cen_x, wen_x, ofifo_rd, l0_rd, execute, load;
  logic [10:0]         a_p, a_x;

  // Number of counted units (reads, cycles or writes) that complete each phase.
  function automatic logic [CW-1:0] phase_len(input state_t s);
    case (s)
      W_FETCH, W_LOAD: phase_len = CW'(col);
      W_GAP:           phase_len = CW'(row);
      A_FETCH, EXEC:   phase_len = CW'(n_act);
      DRAIN:           phase_len = CW'(n_out);
      default:         phase_len = CW'(1);
    endcase
  endfunction

  // Every xmem access is a read into L0, so L0 write trails any read by one cycle.
  assign l0_wr_s  = ~inst_r[19];
  assign w_addr_s = x_w_base + addr_bw'(kij_s) * addr_bw'(col) + addr_bw'(cnt_s);
  assign a_addr_s = x_act_base + addr_bw'(cnt_s);
  assign p_addr_s = p_base + addr_bw'(cnt_s);

  // Phase sequencing: the state/counter pair whose word is issued at the next edge.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    kij_s   = kij_r;
    if (state_r == IDLE) begin
      cnt_s = '0;
      kij_s = 4'd0;
      if (start) begin
        state_s = W_FETCH;
      end else begin
        state_s = IDLE;
      end
    end else if (cnt_r == phase_len(state_r)) begin
      cnt_s = '0;
      case (state_r)
        W_FETCH: state_s = mode ? A_FETCH : W_LOAD;
        W_LOAD:  state_s = W_GAP;
        W_GAP:   state_s = A_FETCH;
        A_FETCH: state_s = EXEC;
        EXEC:    state_s = (!mode || kij_r == KIJ_LAST) ? DRAIN : NEXT;
        DRAIN:   state_s = NEXT;
        NEXT: begin
          if (kij_r == KIJ_LAST) begin
            state_s = FIN;
          end else begin
            state_s = W_FETCH;
            kij_s   = kij_r + 4'd1;
          end
        end
        FIN: begin
          state_s = IDLE;
          kij_s   = 4'd0;
        end
        default: state_s = IDLE;
      endcase
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Word issue for the selected phase; stalls emit the idle word and hold the count.
  always_comb begin
    acc_f = 1'b0; cen_p = 1'b1; wen_p = 1'b1; a_p = 11'd0;
    cen_x = 1'b1; wen_x = 1'b1; a_x = 11'd0;
    ofifo_rd = 1'b0; l0_rd = 1'b0; execute = 1'b0; load = 1'b0;
    take_s = 1'b0;
    case (state_s)
      W_FETCH: begin
        cen_x = 1'b0; a_x = 11'(w_addr_s); take_s = 1'b1;
      end
      W_LOAD: begin
        l0_rd = 1'b1; load = 1'b1; take_s = 1'b1;
      end
      W_GAP, NEXT, FIN: take_s = 1'b1;
      A_FETCH: begin
        if (!l0_o_full) begin
          cen_x = 1'b0; a_x = 11'(a_addr_s); take_s = 1'b1;
        end else begin
          take_s = 1'b0;
        end
      end
      EXEC: begin
        l0_rd = 1'b1; execute = 1'b1; take_s = 1'b1;
      end
      DRAIN: begin
        if (ofifo_valid) begin
          ofifo_rd = 1'b1; cen_p = 1'b0; wen_p = 1'b0; a_p = 11'(p_addr_s);
          acc_f = (kij_s != 4'd0) && !mode;
          take_s = 1'b1;
        end else begin
          take_s = 1'b0;
        end
      end
      default: take_s = 1'b0;
    endcase
    word_s = {acc_f, cen_p, wen_p, a_p, cen_x, wen_x, a_x,
              ofifo_rd, 1'b0, 1'b0, l0_rd, l0_wr_s, execute, load};
  end

  // State, counters and the registered instruction word advance together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      kij_r   <= 4'd0;
      inst_r  <= IDLE_WORD;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s + CW'(take_s);
      kij_r   <= kij_s;
      inst_r  <= word_s;
      busy_r  <= (state_s != IDLE) && (state_s != FIN);
      done_r  <= (state_s == FIN);
    end
  end

  assign inst = inst_r;
  assign busy = busy_r;
  assign done = done_r;
  assign kij  = kij_r;

endmodule

// File: tb/tb_core_inst_seq.sv
// Directed bench for core_inst_seq: WS layer (n_kij=2, n_out=8) on dut_a,
// OS layer (n_kij=3, n_out=16) on dut_b, plus asynchronous reset mid-layer.
module tb_core_inst_seq;
  localparam logic [33:0] IDLE_W = 34'h1800C0000;
  localparam int W_BASE = 100, A_BASE = 2046, P_BASE = 300;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start_a, start_b, mode, l0_o_full, ofifo_valid;
  logic [10:0] x_w_base, x_act_base, p_base;
  logic [33:0] inst_a, inst_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [3:0]  kij_a, kij_b;

  core_inst_seq #(.n_kij(2), .n_out(8)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .mode(mode),
    .x_w_base(x_w_base), .x_act_base(x_act_base), .p_base(p_base),
    .l0_o_full(l0_o_full), .ofifo_valid(ofifo_valid),
    .inst(inst_a), .busy(busy_a), .done(done_a), .kij(kij_a));

  core_inst_seq #(.n_kij(3), .n_out(16)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .mode(mode),
    .x_w_base(x_w_base), .x_act_base(x_act_base), .p_base(p_base),
    .l0_o_full(l0_o_full), .ofifo_valid(ofifo_valid),
    .inst(inst_b), .busy(busy_b), .done(done_b), .kij(kij_b));

  typedef struct {
    logic        start;
    logic [33:0] exp_inst;
    logic        exp_busy;
    logic [3:0]  exp_kij;
  } vec_t;

  int checks = 0, errors = 0;
  int sel;
  int xq[$], pq[$], accq[$], kq[$], exq[$];
  int load_cnt, done_cnt, stall_rd, full_idle, bad_wr;
  logic [33:0] first_pw;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_q(input string name, input int got[$], input int exp[$]);
    int bad;
    bad = (got.size() != exp.size()) ? 1 : 0;
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      if (got[i] != exp[i]) begin
        if (bad == 0) $display("FAIL %s[%0d]: got %0d expected %0d", name, i, got[i], exp[i]);
        bad++;
      end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: size got %0d expected %0d, %0d bad entries", name, got.size(), exp.size(), bad);
    end
  endtask

  // Expected W_FETCH/A_FETCH read word (l0_wr set when the previous word was a read)
  function automatic logic [33:0] rd_word(input int addr, input logic l0wr);
    logic [33:0] w;
    w = IDLE_W;
    w[19] = 1'b0;
    w[17:7] = addr[10:0];
    w[2] = l0wr;
    return w;
  endfunction

  task automatic clear_log();
    xq.delete(); pq.delete(); accq.delete(); kq.delete();
    load_cnt = 0; done_cnt = 0; stall_rd = 0; full_idle = 0; bad_wr = 0;
  endtask

  task automatic tick();
    logic f, v;
    logic [33:0] w;
    f = l0_o_full;
    v = ofifo_valid;
    @(posedge clk);
    #1;
    w = (sel == 1) ? inst_b : inst_a;
    if (!w[19]) begin
      xq.push_back(int'(w[17:7]));
      if (f) stall_rd++;
    end else if (f) begin
      full_idle++;
    end
    if (!w[32]) begin
      if (pq.size() == 0) first_pw = w;
      pq.push_back(int'(w[30:20]));
      accq.push_back(int'(w[33]));
      kq.push_back(int'((sel == 1) ? kij_b : kij_a));
      if (!v) bad_wr++;
    end
    if (w[0]) load_cnt++;
    if ((sel == 1) ? done_b : done_a) done_cnt++;
  endtask

  task automatic build_reads(input int nk);
    exq.delete();
    for (int k = 0; k < nk; k++) begin
      for (int i = 0; i < 8; i++) exq.push_back(W_BASE + 8 * k + i);
      for (int j = 0; j < 36; j++) exq.push_back((A_BASE + j) % 2048);
    end
  endtask

  initial begin
    int bp_left;
    bit bp_done, fin;
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; mode = 1'b0;
    l0_o_full = 1'b0; ofifo_valid = 1'b1; sel = 0;
    x_w_base = 11'(W_BASE); x_act_base = 11'(A_BASE); p_base = 11'(P_BASE);
    first_pw = '0;
    clear_log();

    vecs[0] = '{1'b1, 34'h180043200, 1'b1, 4'd0};
    vecs[1] = '{1'b0, 34'h180043284, 1'b1, 4'd0};
    vecs[2] = '{1'b1, 34'h180043304, 1'b1, 4'd0};
    for (int i = 3; i < 8; i++) vecs[i] = '{1'b0, rd_word(W_BASE + i, 1'b1), 1'b1, 4'd0};
    vecs[8] = '{1'b0, 34'h1800C000D, 1'b1, 4'd0};
    vecs[9] = '{1'b0, 34'h1800C0009, 1'b1, 4'd0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_inst_a", inst_a, IDLE_W);
    chk("rst_busy_a", busy_a, 1'b0);
    chk("rst_done_a", done_a, 1'b0);
    chk("rst_kij_a", kij_a, 4'd0);
    chk("rst_inst_b", inst_b, IDLE_W);
    chk("rst_busy_b", busy_b, 1'b0);
    chk("rst_done_b", done_b, 1'b0);
    chk("rst_kij_b", kij_b, 4'd0);
    @(negedge clk);
    reset = 1'b0;

    // WS layer: start, an ignored start mid-fetch, then the first weight loads
    for (int i = 0; i < 10; i++) begin
      start_a = vecs[i].start;
      tick();
      chk($sformatf("vec%0d_inst", i), inst_a, vecs[i].exp_inst);
      chk($sformatf("vec%0d_busy", i), busy_a, vecs[i].exp_busy);
      chk($sformatf("vec%0d_kij", i), kij_a, vecs[i].exp_kij);
    end
    start_a = 1'b0;

    bp_left = 0; bp_done = 0; fin = 0;
    for (int c = 0; c < 2000 && !fin; c++) begin
      l0_o_full = (bp_left > 0);
      tick();
      if (bp_left > 0) bp_left--;
      else if (!bp_done && !inst_a[19] && inst_a[17:7] == 11'd7) begin
        bp_left = 5;
        bp_done = 1;
      end
      if (done_a) fin = 1;
    end
    l0_o_full = 1'b0;
    chk("ws_done_seen", fin, 1'b1);
    chk("ws_busy_at_done", busy_a, 1'b0);
    repeat (5) tick();
    chk("ws_done_count", done_cnt, 1);
    chk("ws_busy_after", busy_a, 1'b0);
    chk("ws_inst_after", inst_a, IDLE_W);
    build_reads(2);
    cmp_q("ws_xmem_reads", xq, exq);
    chk("ws_stall_reads", stall_rd, 0);
    chk("ws_stall_idle", full_idle, 5);
    chk("ws_loads", load_cnt, 16);
    chk("ws_first_pmem_word", first_pw, 34'h012CC0040);
    exq.delete();
    for (int i = 0; i < 16; i++) exq.push_back(P_BASE + i % 8);
    cmp_q("ws_pmem_addr", pq, exq);
    exq.delete();
    for (int i = 0; i < 16; i++) exq.push_back(i >= 8 ? 1 : 0);
    cmp_q("ws_acc", accq, exq);
    exq.delete();
    for (int i = 0; i < 16; i++) exq.push_back(i / 8);
    cmp_q("ws_drain_kij", kq, exq);

    // OS layer with OFIFO valid toggling every cycle
    sel = 1; mode = 1'b1;
    clear_log();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("os_busy", busy_b, 1'b1);
    fin = 0;
    for (int c = 0; c < 2000 && !fin; c++) begin
      ofifo_valid = (c % 2 == 0);
      tick();
      if (done_b) fin = 1;
    end
    ofifo_valid = 1'b1;
    chk("os_done_seen", fin, 1'b1);
    repeat (3) tick();
    chk("os_done_count", done_cnt, 1);
    chk("os_busy_after", busy_b, 1'b0);
    chk("os_loads", load_cnt, 0);
    chk("os_write_when_invalid", bad_wr, 0);
    build_reads(3);
    cmp_q("os_xmem_reads", xq, exq);
    exq.delete();
    for (int i = 0; i < 16; i++) exq.push_back(P_BASE + i);
    cmp_q("os_pmem_addr", pq, exq);
    exq.delete();
    for (int i = 0; i < 16; i++) exq.push_back(0);
    cmp_q("os_acc", accq, exq);
    exq.delete();
    for (int i = 0; i < 16; i++) exq.push_back(2);
    cmp_q("os_drain_kij", kq, exq);

    // Asynchronous reset during EXEC of kij=1 abandons the layer
    sel = 0; mode = 1'b0;
    clear_log();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    fin = 0;
    for (int c = 0; c < 600 && !fin; c++) begin
      tick();
      if (inst_a[1] && kij_a == 4'd1) fin = 1;
    end
    chk("rst_reached_exec", fin, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_inst", inst_a, IDLE_W);
    chk("arst_busy", busy_a, 1'b0);
    chk("arst_kij", kij_a, 4'd0);
    chk("arst_done", done_a, 1'b0);
    #2;
    reset = 1'b0;
    done_cnt = 0;
    repeat (80) tick();
    chk("arst_no_done", done_cnt, 0);
    chk("arst_busy_after", busy_a, 1'b0);
    chk("arst_inst_after", inst_a, IDLE_W);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
